moxie_ifetch_wb: RTL and testbench
==================================

// Module: moxie_ifetch_wb
// PURPOSE
//  Parametrised Wishbone classic instruction-fetch master with prefetch FIFO.
//  Replaces the single-beat free-running I-bus strobe in the moxie top level.
//  Issues sequential word fetches, buffers up to DEPTH words tagged with their PC,
//  and handles branch redirect by flushing the queue and discarding in-flight replies.
//  Sits between the I-side Wishbone bus and cpu_fetch.
// PARAMETERS
//  AW        32            address width; fetch PC wraps modulo 2**AW
//  DW        32            data width; power of 2, >=16; PC step = DW/8
//  DEPTH     4             prefetch FIFO entries; power of 2, >=2
//  RESET_PC  32'h00001000  first fetch address after reset (AW bits used)
// PORTS
//  clk_i            in   1      clock, all state on rising edge
//  rst_i            in   1      synchronous, active-high reset
//  branch_flag_i    in   1      redirect request from execute, one-cycle pulse
//  branch_target_i  in   AW     redirect address; low log2(DW/8) bits forced to 0
//  wb_adr_o         out  AW     Wishbone address
//  wb_cyc_o         out  1      Wishbone cycle, equals wb_stb_o
//  wb_stb_o         out  1      Wishbone strobe
//  wb_we_o          out  1      constant 0
//  wb_sel_o         out  DW/8   constant all ones
//  wb_dat_i         in   DW     Wishbone read data
//  wb_ack_i         in   1      Wishbone acknowledge
//  wb_err_i         in   1      Wishbone error
//  word_o           out  DW     FIFO head data
//  word_pc_o        out  AW     FIFO head address
//  word_valid_o     out  1      FIFO head valid
//  word_ready_i     in   1      consumer pops head when valid & ready
//  fault_o          out  1      sticky bus-error flag
// BEHAVIOUR
//  Reset: stb/cyc=0, fetch_pc=RESET_PC, FIFO empty, word_valid_o=0, fault_o=0,
//   state=IDLE; reset mid-transaction drops stb at the same edge; a late ack is ignored.
//  States: IDLE (no request), BUS (stb held, awaiting ack/err), DISCARD (stb held,
//   reply to be dropped because a redirect arrived).
//  IDLE->BUS when !fault_o and (count + pops_pending) < DEPTH: wb_adr_o=fetch_pc,
//   registered, so stb rises the cycle after the decision.
//  BUS: stb held until ack|err (Wishbone classic, never retracted early).
//   On ack: push {fetch_pc, wb_dat_i}; fetch_pc += DW/8; if slot free, re-issue
//   back-to-back (stb stays high, address advances); otherwise go to IDLE.
//  Slot reservation: a request is issued only if the FIFO can accept its reply,
//   so push never meets a full FIFO.
//  Redirect (branch_flag_i=1): FIFO cleared and fetch_pc=target at the next edge;
//   word_valid_o=0 for at least one cycle. If stb is outstanding and not acked
//   this cycle -> DISCARD; reply dropped; first target fetch issued after ack.
//  Redirect in the same cycle as ack: ack data discarded; the target request is
//   issued next cycle.
//  Redirect in the same cycle as a pop: the flush wins; the pop has no other effect.
//  Push and pop in the same cycle: count is unchanged; the head advances.
//  wb_err_i in BUS: drop stb, set fault_o, go to IDLE, no push; fetching halts
//   until a redirect (clears fault_o) or reset. wb_err_i in DISCARD: dropped, no fault.
//  word_o/word_pc_o are valid only when word_valid_o=1; they do not change while
//   valid & !ready.
//  Max throughput: 1 word/cycle with zero-wait slave; fetch latency 2 cycles from
//   IDLE to first word_valid_o with a 1-cycle ack.
// STRUCTURE
//  moxie_pkg: fetch state enum {IDLE,BUS,DISCARD}; WB_SEL_ALL constant; clog2 function.
//  Sub-module moxie_sync_fifo #(WIDTH=AW+DW, DEPTH): sync clear, push/pop, count,
//   full/empty; this block holds the FSM and fetch_pc.
// TESTING
//  T1 reset, 0-wait slave returns mem[a]=a^32'hA5A5A5A5, ready=1 -> words at
//     0x1000,0x1004,0x1008... in order; one word/cycle after the first.
//  T2 ready=0 for 20 cycles -> exactly DEPTH=4 words buffered, stb low, head stable;
//     ready=1 -> drains in order, fetching resumes at 0x1010.
//  T3 branch to 0x2002 while stb pending, ack 3 cycles later -> that reply dropped;
//     next word_pc_o=0x2000; no 0x10xx word after the flush.
//  T4 branch coincident with ack -> acked word never appears; next adr=target.
//  T5 wb_err_i on fetch 0x1008 -> fault_o=1, stb stays low; branch 0x3000 ->
//     fault_o=0, fetch restarts at 0x3000.
//  T6 branch to 0xFFFFFFFC -> words at 0xFFFFFFFC then 0x00000000 (wrap);
//     rst_i mid-BUS -> stb low next edge, restart at 0x1000.

Source files
------------

// File: rtl/moxie_pkg.sv
// Shared definitions for the moxie instruction-fetch path.
//   fetch_state_e : Wishbone fetch master states
//   WB_SEL_ALL    : all-ones byte-select source, sliced to DW/8 by users
//   clog2         : ceiling log2 for sizing pointers and counters
package moxie_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // no request on the bus
    ST_BUS     = 2'd1,  // strobe held, reply will be kept
    ST_DISCARD = 2'd2   // strobe held, reply will be dropped (redirected)
  } fetch_state_e;

  localparam logic [127:0] WB_SEL_ALL = '1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/moxie_sync_fifo.sv
// Small synchronous show-ahead FIFO used as the instruction prefetch queue.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   clr_i           synchronous flush (pointers and count to zero)
//   push_i, din_i   write request and data (ignored when full)
//   pop_i           read request (ignored when empty)
//   dout_o          head entry, valid while !empty_o
//   count_o         number of stored entries (0..DEPTH)
//   full_o, empty_o status flags
module moxie_sync_fifo
  import moxie_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        din_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        dout_o,
  output logic [clog2(DEPTH):0]   count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int PW = clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW:0]      r_count;

  logic w_push;
  logic w_pop;

  assign w_push = push_i & (r_count != DEPTH_C);
  assign w_pop  = pop_i & (r_count != '0);

  // Storage is never reset: a flush only moves the pointers, stale
  // entries are unreachable until overwritten.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;
  assign full_o  = (r_count == DEPTH_C);
  assign empty_o = (r_count == '0);

endmodule

// File: rtl/moxie_ifetch_wb.sv
// Wishbone classic instruction-fetch master with a prefetch FIFO.
// Fetches sequential words, tags each with its address, and hands them to
// the fetch stage through a valid/ready head. A branch redirect flushes the
// queue and drops any reply still in flight.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   branch_flag_i/target_i       one-cycle redirect pulse and target address
//   wb_*                         Wishbone classic read master (I-side)
//   word_o/word_pc_o/valid_o     FIFO head data, its address, head valid
//   word_ready_i                 consumer pops head when valid & ready
//   fault_o                      sticky bus-error flag, cleared by redirect
module moxie_ifetch_wb
  import moxie_pkg::*;
#(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = AW'(32'h0000_1000)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            branch_flag_i,
  input  logic [AW-1:0]   branch_target_i,
  output logic [AW-1:0]   wb_adr_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [DW/8-1:0] wb_sel_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  output logic [DW-1:0]   word_o,
  output logic [AW-1:0]   word_pc_o,
  output logic            word_valid_o,
  input  logic            word_ready_i,
  output logic            fault_o
);

  localparam int            BW         = DW / 8;
  localparam int            CW         = clog2(DEPTH) + 1;
  localparam logic [AW-1:0] PC_STEP    = AW'(BW);
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(BW - 1);

  fetch_state_e   r_state;
  fetch_state_e   w_state_next;
  logic [AW-1:0]  r_adr;           // address currently on the bus
  logic [AW-1:0]  w_adr_next;
  logic [AW-1:0]  r_fetch_pc;      // address of the next request to issue
  logic [AW-1:0]  w_fetch_pc_next;
  logic           r_fault;
  logic           w_fault_next;

  logic           w_push_req;
  logic           w_push;
  logic           w_pop;
  logic           w_flush;
  logic           w_bus_done;
  logic [AW-1:0]  w_target;
  logic [CW-1:0]  w_count;
  logic [CW:0]    w_count_after_ack;
  logic           w_full;
  logic           w_empty;
  logic [AW+DW-1:0] w_head;

  assign w_target   = branch_target_i & ALIGN_MASK;
  assign w_bus_done = (r_state != ST_IDLE) && (wb_ack_i || wb_err_i);
  assign w_pop      = word_valid_o & word_ready_i;

  // Occupancy once this cycle's ack is pushed and any pop retired; the next
  // request may only go out if its reply is guaranteed a slot.
  assign w_count_after_ack = {1'b0, w_count} + (CW+1)'(1) - (CW+1)'(w_pop);

  always_comb begin
    w_state_next    = r_state;
    w_adr_next      = r_adr;
    w_fetch_pc_next = r_fetch_pc;
    w_fault_next    = r_fault;
    w_push_req      = 1'b0;
    w_flush         = 1'b0;

    if (branch_flag_i) begin
      // Redirect overrides everything: any ack this cycle is not pushed and
      // a concurrent pop only disappears into the flush.
      w_flush      = 1'b1;
      w_fault_next = 1'b0;
      if ((r_state != ST_IDLE) && !(wb_ack_i || wb_err_i)) begin
        // Strobe cannot be retracted; wait for the stale reply first.
        w_state_next    = ST_DISCARD;
        w_fetch_pc_next = w_target;
      end else begin
        w_state_next    = ST_BUS;
        w_adr_next      = w_target;
        w_fetch_pc_next = w_target + PC_STEP;
      end
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (!r_fault && (w_count < CW'(DEPTH))) begin
            w_state_next    = ST_BUS;
            w_adr_next      = r_fetch_pc;
            w_fetch_pc_next = r_fetch_pc + PC_STEP;
          end
        end
        ST_BUS: begin
          if (wb_err_i) begin
            w_state_next = ST_IDLE;
            w_fault_next = 1'b1;
          end else if (wb_ack_i) begin
            w_push_req = 1'b1;
            if (w_count_after_ack < (CW+1)'(DEPTH)) begin
              w_adr_next      = r_fetch_pc;
              w_fetch_pc_next = r_fetch_pc + PC_STEP;
            end else begin
              w_state_next = ST_IDLE;
            end
          end
        end
        ST_DISCARD: begin
          // Reply (ack or err) is dropped; go straight to the target fetch.
          if (wb_ack_i || wb_err_i) begin
            w_state_next    = ST_BUS;
            w_adr_next      = r_fetch_pc;
            w_fetch_pc_next = r_fetch_pc + PC_STEP;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_adr      <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_adr      <= w_adr_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_fault    <= w_fault_next;
    end
  end

  // Reservation makes full-on-push impossible; the gate only keeps the
  // queue consistent if that ever breaks.
  assign w_push = w_push_req & ~w_full;

  moxie_sync_fifo #(
    .WIDTH (AW + DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (w_flush),
    .push_i  (w_push),
    .din_i   ({r_adr, wb_dat_i}),
    .pop_i   (w_pop),
    .dout_o  (w_head),
    .count_o (w_count),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign wb_adr_o     = r_adr;
  assign wb_stb_o     = (r_state != ST_IDLE);
  assign wb_cyc_o     = wb_stb_o;
  assign wb_we_o      = 1'b0;
  assign wb_sel_o     = WB_SEL_ALL[DW/8-1:0];
  assign word_pc_o    = w_head[AW+DW-1:DW];
  assign word_o       = w_head[DW-1:0];
  assign word_valid_o = ~w_empty;
  assign fault_o      = r_fault;

endmodule

// File: tb/tb_moxie_ifetch_wb.sv
// Testbench for moxie_ifetch_wb: Wishbone slave model with programmable
// wait states and error address, plus an expected-word scoreboard.
module tb_moxie_ifetch_wb;

  logic        clk;
  logic        rst;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic [31:0] wb_adr;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat;
  logic        wb_ack;
  logic        wb_err;
  logic [31:0] word;
  logic [31:0] word_pc;
  logic        word_valid;
  logic        word_ready;
  logic        fault;

  moxie_ifetch_wb dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .branch_flag_i   (branch_flag),
    .branch_target_i (branch_target),
    .wb_adr_o        (wb_adr),
    .wb_cyc_o        (wb_cyc),
    .wb_stb_o        (wb_stb),
    .wb_we_o         (wb_we),
    .wb_sel_o        (wb_sel),
    .wb_dat_i        (wb_dat),
    .wb_ack_i        (wb_ack),
    .wb_err_i        (wb_err),
    .word_o          (word),
    .word_pc_o       (word_pc),
    .word_valid_o    (word_valid),
    .word_ready_i    (word_ready),
    .fault_o         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: acks s_lat cycles after strobe rises, errors on s_err_adr.
  logic [3:0]  s_lat;
  logic        s_err_en;
  logic [31:0] s_err_adr;
  logic [3:0]  s_wait;
  int          n_acks = 0;

  assign wb_dat = wb_adr ^ 32'hA5A5A5A5;

  always_comb begin
    wb_ack = 1'b0;
    wb_err = 1'b0;
    if (wb_stb && (s_wait >= s_lat)) begin
      if (s_err_en && (wb_adr == s_err_adr)) wb_err = 1'b1;
      else                                   wb_ack = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!wb_stb || wb_ack || wb_err) s_wait <= '0;
    else                             s_wait <= s_wait + 1'b1;
    if (wb_ack) n_acks <= n_acks + 1;
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] pc);
    sb_q.push_back({pc, pc ^ 32'hA5A5A5A5});
  endtask

  // Called at a negedge. Raises ready and checks every word popped until n
  // words are seen, then drops ready one negedge later (after the last pop).
  task automatic consume(input int n, input int budget, output int first_i, output int last_i);
    int got;
    int i;
    logic [63:0] e;
    got = 0; i = 0; first_i = -1; last_i = -1;
    word_ready = 1'b1;
    while (1) begin
      if (word_valid && word_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_word", {word_pc, word}, 64'h0);
        end else begin
          e = sb_q.pop_front();
          $display("word pc=%h dat=%h (exp pc=%h)", word_pc, word, e[63:32]);
          check_eq("word_pc", {32'h0, word_pc}, {32'h0, e[63:32]});
          check_eq("word_dat", {32'h0, word}, {32'h0, e[31:0]});
        end
        got++;
        if (first_i < 0) first_i = i;
        last_i = i;
      end
      if (got == n) break;
      if (i == budget) begin
        check_eq("consume_timeout", 64'(got), 64'(n));
        break;
      end
      @(negedge clk);
      i++;
    end
    if (got == n) @(negedge clk);
    word_ready = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  int f_i, l_i, acks0;
  logic [31:0] head_pc0;

  initial begin
    rst = 1'b1; branch_flag = 1'b0; branch_target = '0; word_ready = 1'b0;
    s_lat = 4'd0; s_err_en = 1'b0; s_err_adr = 32'h0;

    // T0 reset state
    repeat (3) @(negedge clk);
    check_eq("rst_stb", 64'(wb_stb), 64'd0);
    check_eq("rst_cyc", 64'(wb_cyc), 64'd0);
    check_eq("rst_valid", 64'(word_valid), 64'd0);
    check_eq("rst_fault", 64'(fault), 64'd0);
    check_eq("rst_we", 64'(wb_we), 64'd0);
    check_eq("rst_sel", 64'(wb_sel), 64'hF);

    // T1 zero-wait streaming: first word 2 cycles after release, then 1/cycle
    for (int k = 0; k < 8; k++) exp_push(32'h1000 + 32'(4 * k));
    rst = 1'b0;
    consume(8, 50, f_i, l_i);
    check_eq("t1_latency", 64'(f_i), 64'd2);
    check_eq("t1_throughput", 64'(l_i - f_i), 64'd7);

    // T2 consumer stalled: exactly DEPTH words fetched, bus idle, head stable
    do_reset(3);
    acks0 = n_acks;
    repeat (5) @(negedge clk);
    head_pc0 = word_pc;
    repeat (15) @(negedge clk);
    check_eq("t2_acks", 64'(n_acks - acks0), 64'd4);
    check_eq("t2_stb_low", 64'(wb_stb), 64'd0);
    check_eq("t2_valid", 64'(word_valid), 64'd1);
    check_eq("t2_head_early", 64'(head_pc0), 64'h1000);
    check_eq("t2_head_late", 64'(word_pc), 64'h1000);
    for (int k = 0; k < 6; k++) exp_push(32'h1000 + 32'(4 * k));
    consume(6, 50, f_i, l_i);

    // T3 redirect while a slow request is pending: its reply is dropped
    s_lat = 4'd3;
    do_reset(3);
    @(negedge clk);
    check_eq("t3_stb_up", 64'(wb_stb), 64'd1);
    branch_flag = 1'b1; branch_target = 32'h2002;
    @(negedge clk);
    branch_flag = 1'b0;
    check_eq("t3_discard_stb", 64'(wb_stb), 64'd1);
    check_eq("t3_discard_adr", 64'(wb_adr), 64'h1000);
    check_eq("t3_flush_valid", 64'(word_valid), 64'd0);
    for (int k = 0; k < 3; k++) exp_push(32'h2000 + 32'(4 * k));
    consume(3, 100, f_i, l_i);

    // T4 redirect coincident with an ack (and with a pop)
    s_lat = 4'd0;
    do_reset(3);
    repeat (3) @(negedge clk);
    check_eq("t4_pre_adr", 64'(wb_adr), 64'h1008);
    check_eq("t4_pre_ack", 64'(wb_ack), 64'd1);
    branch_flag = 1'b1; branch_target = 32'h2400; word_ready = 1'b1;
    @(negedge clk);
    branch_flag = 1'b0;
    check_eq("t4_next_adr", 64'(wb_adr), 64'h2400);
    check_eq("t4_next_stb", 64'(wb_stb), 64'd1);
    check_eq("t4_flush_valid", 64'(word_valid), 64'd0);
    exp_push(32'h2400); exp_push(32'h2404);
    consume(2, 50, f_i, l_i);

    // T5 bus error halts fetching until a redirect
    s_err_en = 1'b1; s_err_adr = 32'h1008;
    do_reset(3);
    exp_push(32'h1000); exp_push(32'h1004);
    consume(2, 50, f_i, l_i);
    repeat (5) @(negedge clk);
    check_eq("t5_fault", 64'(fault), 64'd1);
    check_eq("t5_stb_low", 64'(wb_stb), 64'd0);
    check_eq("t5_no_word", 64'(word_valid), 64'd0);
    branch_flag = 1'b1; branch_target = 32'h3000;
    @(negedge clk);
    branch_flag = 1'b0;
    check_eq("t5_fault_clr", 64'(fault), 64'd0);
    check_eq("t5_restart_adr", 64'(wb_adr), 64'h3000);
    exp_push(32'h3000); exp_push(32'h3004);
    consume(2, 50, f_i, l_i);

    // T6 address wrap, then reset in the middle of a bus cycle
    s_err_en = 1'b0;
    branch_flag = 1'b1; branch_target = 32'hFFFF_FFFC;
    @(negedge clk);
    branch_flag = 1'b0;
    exp_push(32'hFFFF_FFFC); exp_push(32'h0000_0000); exp_push(32'h0000_0004);
    consume(3, 50, f_i, l_i);
    s_lat = 4'd5;
    branch_flag = 1'b1; branch_target = 32'h4000;
    @(negedge clk);
    branch_flag = 1'b0;
    check_eq("t6_stb_pending", 64'(wb_stb), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_stb", 64'(wb_stb), 64'd0);
    check_eq("t6_rst_adr", 64'(wb_adr), 64'h1000);
    s_lat = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_push(32'h1000); exp_push(32'h1004);
    consume(2, 50, f_i, l_i);
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
